// File: rtl/obstacle_field_if.sv
// Control and display bus between the game FSM/renderer and the obstacle field.
// The renderer and collision checker consume the formatted rectangles.
interface obstacle_field_if #(
    parameter int NUM_OBS = 3
);
    logic                    frame_tick;
    logic                    start;
    logic                    halt;
    logic [NUM_OBS*10-1:0]   obs_left;
    logic [NUM_OBS*10-1:0]   obs_right;
    logic [NUM_OBS*9-1:0]    gap_top;
    logic [NUM_OBS*9-1:0]    gap_bot;
    logic [NUM_OBS-1:0]      obs_visible;
    logic                    score_pulse;
    logic                    running;

    modport master (
        output frame_tick, start, halt,
        input  obs_left, obs_right, gap_top, gap_bot, obs_visible, score_pulse, running
    );

    modport slave (
        input  frame_tick, start, halt,
        output obs_left, obs_right, gap_top, gap_bot, obs_visible, score_pulse, running
    );
endinterface

// File: rtl/obstacle_field.sv
// Scrolling pipe obstacles for Flappy Bird: per-channel right-edge position and
// gap centre, LFSR-driven respawn, and VGA-ready rectangle formatting.
module obstacle_field #(
    parameter int          NUM_OBS       = 3,
    parameter int          OBS_WIDTH     = 60,
    parameter int          SPACING       = 240,
    parameter int          SPEED         = 2,
    parameter int          SCREEN_WIDTH  = 640,
    parameter int          SCREEN_HEIGHT = 480,
    parameter int          GAP           = 120,
    parameter int          MARGIN        = 40,
    parameter int          BIRD_X        = 160,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic           clk,
    input  logic           reset_n,
    obstacle_field_if.slave bus
);
    localparam int         RANGE      = SCREEN_HEIGHT - 2*MARGIN - GAP;
    localparam logic [10:0] L_SPEED   = 11'(SPEED);
    localparam logic [10:0] L_PERIOD  = 11'(NUM_OBS*SPACING);
    localparam logic [10:0] L_OBS_W   = 11'(OBS_WIDTH);
    localparam logic [10:0] L_SCR_W   = 11'(SCREEN_WIDTH);
    localparam logic [10:0] L_BIRD    = 11'(BIRD_X);
    localparam logic [8:0]  L_RANGE   = 9'(RANGE);
    localparam logic [8:0]  L_CTR_BASE = 9'(MARGIN + GAP/2);
    localparam logic [8:0]  L_HALF_GAP = 9'(GAP/2);
    localparam logic [8:0]  L_CTR_INIT = 9'(SCREEN_HEIGHT/2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FREEZE} state_t;

    state_t r_state, w_state_nxt;
    logic   w_move, w_reload;
    logic [15:0] r_lfsr;
    logic        w_fb;
    logic        r_score;
    logic [NUM_OBS-1:0]       w_cross;
    logic [NUM_OBS-1:0][9:0]  w_left, w_right;
    logic [NUM_OBS-1:0][8:0]  w_top, w_bot;
    logic [NUM_OBS-1:0]       w_vis;

    // halt wins over a same-cycle frame_tick; leaving FREEZE reloads the field
    always_comb begin
        w_state_nxt = r_state;
        w_move      = 1'b0;
        w_reload    = 1'b0;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (bus.halt)            w_state_nxt = S_FREEZE;
                else if (bus.frame_tick) w_move      = 1'b1;
            end
            S_FREEZE: if (bus.start) begin
                w_state_nxt = S_IDLE;
                w_reload    = 1'b1;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Fibonacci taps 16,14,13,11; free-running so player timing adds entropy
    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_lfsr <= LFSR_SEED;
        else          r_lfsr <= {r_lfsr[14:0], w_fb};
    end

    for (genvar i = 0; i < NUM_OBS; i++) begin : g_ch
        localparam logic [10:0] L_POS_INIT = 11'(SCREEN_WIDTH + OBS_WIDTH + i*SPACING);

        logic [10:0] r_pos;
        logic [8:0]  r_ctr;
        logic [10:0] w_pos_mv;
        logic        w_respawn;
        logic [8:0]  w_v;
        logic [8:0]  w_new_ctr;
        logic [10:0] w_lft_raw;

        // channel i draws from the LFSR rotated left by i so simultaneous respawns differ
        assign w_v       = 9'(({r_lfsr, r_lfsr} >> (16 - i)));
        assign w_new_ctr = L_CTR_BASE + ((w_v >= L_RANGE) ? (w_v - L_RANGE) : w_v);
        assign w_respawn = (r_pos <= L_SPEED);
        // modulo-2048 wrap of pos-SPEED is undone by adding the period, so no drift
        assign w_pos_mv  = w_respawn ? (r_pos - L_SPEED + L_PERIOD) : (r_pos - L_SPEED);
        assign w_cross[i] = (r_pos > L_BIRD) && (w_pos_mv <= L_BIRD);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_pos <= L_POS_INIT;
                r_ctr <= L_CTR_INIT;
            end else if (w_reload) begin
                r_pos <= L_POS_INIT;
                r_ctr <= L_CTR_INIT;
            end else if (w_move) begin
                r_pos <= w_pos_mv;
                if (w_respawn) r_ctr <= w_new_ctr;
            end
        end

        assign w_lft_raw = (r_pos >= L_OBS_W) ? (r_pos - L_OBS_W) : 11'd0;
        assign w_left[i]  = (w_lft_raw > 11'd1023) ? 10'h3FF : w_lft_raw[9:0];
        assign w_right[i] = (r_pos > (L_SCR_W - 11'd1)) ? 10'(SCREEN_WIDTH - 1) : r_pos[9:0];
        assign w_top[i]   = r_ctr - L_HALF_GAP;
        assign w_bot[i]   = r_ctr + L_HALF_GAP;
        assign w_vis[i]   = (r_pos != 11'd0) && (r_pos < (L_SCR_W + L_OBS_W));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_score <= 1'b0;
        else          r_score <= w_move && (|w_cross);
    end

    assign bus.obs_left    = w_left;
    assign bus.obs_right   = w_right;
    assign bus.gap_top     = w_top;
    assign bus.gap_bot     = w_bot;
    assign bus.obs_visible = w_vis;
    assign bus.score_pulse = r_score;
    assign bus.running     = (r_state == S_RUN);
endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field with a reference model feeding a scoreboard queue.
module tb_obstacle_field;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    obstacle_field_if #(.NUM_OBS(3)) bus ();

    obstacle_field dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [29:0] left;
        logic [29:0] right;
        logic [26:0] top;
        logic [26:0] bot;
        logic [2:0]  vis;
        logic        score;
        logic        run;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pulse = 0;

    int   m_pos[3];
    int   m_ctr[3];
    int   m_st;
    logic [15:0] m_lfsr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
        return (x << n) | (x >> (16 - n));
    endfunction

    task automatic model_init();
        for (int i = 0; i < 3; i++) begin
            m_pos[i] = 700 + i*240;
            m_ctr[i] = 240;
        end
        m_st = 0;
    endtask

    function automatic exp_t model_out(input logic sc);
        exp_t e;
        int l, r;
        for (int i = 0; i < 3; i++) begin
            l = (m_pos[i] >= 60) ? m_pos[i] - 60 : 0;
            if (l > 1023) l = 1023;
            r = (m_pos[i] > 639) ? 639 : m_pos[i];
            e.left[10*i +: 10] = 10'(l);
            e.right[10*i +: 10] = 10'(r);
            e.top[9*i +: 9] = 9'(m_ctr[i] - 60);
            e.bot[9*i +: 9] = 9'(m_ctr[i] + 60);
            e.vis[i] = (m_pos[i] > 0) && (m_pos[i] < 700);
        end
        e.score = sc;
        e.run = (m_st == 1);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_left"},  64'(bus.obs_left),  64'({10'd1023, 10'd880, 10'd640}));
        chk({tag, "_right"}, 64'(bus.obs_right), 64'({10'd639, 10'd639, 10'd639}));
        chk({tag, "_top"},   64'(bus.gap_top),   64'({9'd180, 9'd180, 9'd180}));
        chk({tag, "_bot"},   64'(bus.gap_bot),   64'({9'd300, 9'd300, 9'd300}));
        chk({tag, "_vis"},   64'(bus.obs_visible), 64'(3'b000));
        chk({tag, "_score"}, 64'(bus.score_pulse), 64'(1'b0));
        chk({tag, "_run"},   64'(bus.running),   64'(1'b0));
    endtask

    // Drive one cycle of inputs, advance the model, then compare against the popped expectation.
    task automatic step(input logic ft, input logic st, input logic hl);
        exp_t e;
        logic sc;
        int   np, v;
        @(negedge clk);
        bus.frame_tick = ft;
        bus.start      = st;
        bus.halt       = hl;
        sc = 1'b0;
        case (m_st)
            0: if (st) m_st = 1;
            1: begin
                if (hl) m_st = 2;
                else if (ft) begin
                    for (int i = 0; i < 3; i++) begin
                        if (m_pos[i] > 2) np = m_pos[i] - 2;
                        else begin
                            np = m_pos[i] - 2 + 720;
                            v = int'(rotl(m_lfsr, i) & 16'h01FF);
                            m_ctr[i] = 100 + ((v >= 280) ? v - 280 : v);
                        end
                        if (m_pos[i] > 160 && np <= 160) sc = 1'b1;
                        m_pos[i] = np;
                    end
                end
            end
            default: if (st) model_init();
        endcase
        sb.push_back(model_out(sc));
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.halt       = 1'b0;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("left",  64'(bus.obs_left),    64'(e.left));
            chk("right", 64'(bus.obs_right),   64'(e.right));
            chk("top",   64'(bus.gap_top),     64'(e.top));
            chk("bot",   64'(bus.gap_bot),     64'(e.bot));
            chk("vis",   64'(bus.obs_visible), 64'(e.vis));
            chk("score", 64'(bus.score_pulse), 64'(e.score));
            chk("run",   64'(bus.running),     64'(e.run));
        end
        if (bus.score_pulse) n_pulse++;
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.halt       = 1'b0;
        model_init();

        // reset state
        #12;
        chk_reset_vals("reset");
        chk("reset_lfsr", 64'(dut.r_lfsr), 64'(16'hACE1));
        @(negedge clk);
        reset_n = 1'b1;

        // idle ignores frame_tick
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0);
        chk_reset_vals("idle");

        // start then 30 ticks
        step(1'b0, 1'b1, 1'b0);
        chk("running", 64'(bus.running), 64'(1'b1));
        for (int k = 0; k < 30; k++) step(1'b1, 1'b0, 1'b0);
        chk("t30_left0",  64'(bus.obs_left[9:0]),  64'(10'd580));
        chk("t30_right0", 64'(bus.obs_right[9:0]), 64'(10'd639));
        chk("t30_vis0",   64'(bus.obs_visible[0]), 64'(1'b1));
        chk("t30_spacing", 64'(bus.obs_left[19:10] - bus.obs_left[9:0]), 64'(10'd240));

        // down to pos0 = 2; crossing of BIRD_X at tick 270 gives one pulse
        for (int k = 0; k < 319; k++) step(1'b1, 1'b0, 1'b0);
        chk("t349_right0", 64'(bus.obs_right[9:0]), 64'(10'd2));
        chk("t349_left0",  64'(bus.obs_left[9:0]),  64'(10'd0));
        chk("pulses_ch0",  64'(n_pulse), 64'(1));

        // respawn
        step(1'b1, 1'b0, 1'b0);
        chk("resp_left0",  64'(bus.obs_left[9:0]),  64'(10'd660));
        chk("resp_right0", 64'(bus.obs_right[9:0]), 64'(10'd639));
        chk("resp_vis0",   64'(bus.obs_visible[0]), 64'(1'b0));
        chk("resp_gapw",   64'(bus.gap_bot[8:0] - bus.gap_top[8:0]), 64'(9'd120));
        chk("resp_ctr_lo", 64'(bus.gap_top[8:0] >= 9'd40),  64'(1'b1));
        chk("resp_ctr_hi", 64'(bus.gap_top[8:0] <= 9'd319), 64'(1'b1));

        // channel 1 crosses 120 ticks after channel 0
        for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 1'b0);
        chk("pulses_ch1", 64'(n_pulse), 64'(2));

        // halt with same-cycle tick: no movement, then frozen
        step(1'b1, 1'b0, 1'b1);
        chk("frz_run", 64'(bus.running), 64'(1'b0));
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk_reset_vals("unfreeze");

        // async reset mid-run
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        model_init();
        #1;
        chk_reset_vals("midrst");
        chk("midrst_lfsr", 64'(dut.r_lfsr), 64'(16'hACE1));
        @(negedge clk);
        reset_n = 1'b1;

        // respawn after reset exercises the reloaded LFSR sequence
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 350; k++) step(1'b1, 1'b0, 1'b0);
        chk("post_rst_right0", 64'(bus.obs_right[9:0]), 64'(10'd639));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
